// File: rtl/ysyx_23060191_idu_pkg.sv
// Shared decode definitions for the IDU: opcode/funct3 constants, ALU codes,
// decoded-entry layout and skid-buffer states.
package ysyx_23060191_idu_pkg;

   localparam logic [6:0] TYPE_I       = 7'b0010011;
   localparam logic [6:0] TYPE_R       = 7'b0110011;
   localparam logic [6:0] TYPE_S       = 7'b0100011;
   localparam logic [6:0] TYPE_B       = 7'b1100011;
   localparam logic [6:0] TYPE_U_LUI   = 7'b0110111;
   localparam logic [6:0] TYPE_U_AUIPC = 7'b0010111;
   localparam logic [6:0] TYPE_J       = 7'b1101111;
   localparam logic [6:0] TYPE_JALR    = 7'b1100111;
   localparam logic [6:0] TYPE_LOAD    = 7'b0000011;
   localparam logic [6:0] TYPE_SYS     = 7'b1110011;

   localparam logic [2:0] FUNC3_ADD_SUB = 3'b000;
   localparam logic [2:0] FUNC3_SLL     = 3'b001;
   localparam logic [2:0] FUNC3_SLT     = 3'b010;
   localparam logic [2:0] FUNC3_SLTU    = 3'b011;
   localparam logic [2:0] FUNC3_XOR     = 3'b100;
   localparam logic [2:0] FUNC3_SR      = 3'b101;
   localparam logic [2:0] FUNC3_OR      = 3'b110;
   localparam logic [2:0] FUNC3_AND     = 3'b111;

   localparam logic [6:0]  FUNC7_BASE  = 7'b0000000;
   localparam logic [6:0]  FUNC7_ALT   = 7'b0100000;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      alu_op_e     alu_op;
      logic        src1_pc;
      logic        src2_imm;
      logic        wen;
      logic        illegal;
      logic        ebreak;
   } dec_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } buf_state_e;

   // funct7[5] means SUB only on register-register ops, SRA on both classes.
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt,
                                           input logic is_reg);
      alu_op_e op;
      case (f3)
         FUNC3_ADD_SUB: op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
         FUNC3_SLL:     op = ALU_SLL;
         FUNC3_SLT:     op = ALU_SLT;
         FUNC3_SLTU:    op = ALU_SLTU;
         FUNC3_XOR:     op = ALU_XOR;
         FUNC3_SR:      op = alt ? ALU_SRA : ALU_SRL;
         FUNC3_OR:      op = ALU_OR;
         default:       op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ysyx_23060191_idu_dec.sv
// Combinational RV32I instruction decoder. Define YSYX_23060191_RV32E_EN to
// restrict register indices to x0..x15 (higher indices decode as illegal).
module ysyx_23060191_idu_dec
   import ysyx_23060191_idu_pkg::*;
(
   input  logic [31:0] inst_i,
   output dec_t        dec_o
);

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = inst_i[6:0];
   assign f3     = inst_i[14:12];
   assign f7     = inst_i[31:25];
   assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u  = {inst_i[31:12], 12'b0};
   assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   logic        use_rs1, use_rs2, use_rd;
   logic        ill, ebrk, s1pc, s2imm;
   logic [31:0] imm;
   alu_op_e     alu;

   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      ill     = 1'b0;
      ebrk    = 1'b0;
      s1pc    = 1'b0;
      s2imm   = 1'b0;
      imm     = '0;
      alu     = ALU_ADD;
      case (opcode)
         TYPE_R: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            use_rd  = 1'b1;
            alu     = alu_from_f3(f3, f7[5], 1'b1);
            ill     = !((f7 == FUNC7_BASE) ||
                        (f7 == FUNC7_ALT && (f3 == FUNC3_ADD_SUB || f3 == FUNC3_SR)));
         end
         TYPE_I: begin
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            s2imm   = 1'b1;
            imm     = imm_i;
            alu     = alu_from_f3(f3, f7[5], 1'b0);
            if (f3 == FUNC3_SLL) ill = (f7 != FUNC7_BASE);
            if (f3 == FUNC3_SR)  ill = (f7 != FUNC7_BASE) && (f7 != FUNC7_ALT);
         end
         TYPE_U_LUI: begin
            use_rd = 1'b1;
            s2imm  = 1'b1;
            imm    = imm_u;
            alu    = ALU_PASSB;
         end
         TYPE_U_AUIPC: begin
            use_rd = 1'b1;
            s1pc   = 1'b1;
            s2imm  = 1'b1;
            imm    = imm_u;
         end
         TYPE_J: begin
            use_rd = 1'b1;
            s1pc   = 1'b1;
            s2imm  = 1'b1;
            imm    = imm_j;
         end
         TYPE_JALR: begin
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            s2imm   = 1'b1;
            imm     = imm_i;
         end
         TYPE_LOAD: begin
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            s2imm   = 1'b1;
            imm     = imm_i;
            ill     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         TYPE_S: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            s2imm   = 1'b1;
            imm     = imm_s;
            ill     = f3[2] || (f3 == 3'b011);
         end
         TYPE_B: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm     = imm_b;
            case (f3[2:1])
               2'b00:   alu = ALU_SUB;
               2'b10:   alu = ALU_SLT;
               2'b11:   alu = ALU_SLTU;
               default: ill = 1'b1;
            endcase
         end
         TYPE_SYS: begin
            if (inst_i == INST_EBREAK) ebrk = 1'b1;
            else                       ill  = 1'b1;
         end
         default: ill = 1'b1;
      endcase
      if (inst_i[1:0] != 2'b11) ill = 1'b1;
`ifdef YSYX_23060191_RV32E_EN
      if ((use_rs1 && inst_i[19]) || (use_rs2 && inst_i[24]) || (use_rd && inst_i[11]))
         ill = 1'b1;
`endif

      // Illegal encodings collapse to an all-zero entry flagged illegal.
      dec_o = '0;
      if (ill) begin
         dec_o.illegal = 1'b1;
      end else begin
         dec_o.imm      = imm;
         dec_o.rs1      = use_rs1 ? inst_i[19:15] : 5'd0;
         dec_o.rs2      = use_rs2 ? inst_i[24:20] : 5'd0;
         dec_o.rd       = use_rd  ? inst_i[11:7]  : 5'd0;
         dec_o.alu_op   = alu;
         dec_o.src1_pc  = s1pc;
         dec_o.src2_imm = s2imm;
         dec_o.wen      = use_rd && (inst_i[11:7] != 5'd0);
         dec_o.ebreak   = ebrk;
      end
   end

endmodule

// File: rtl/ysyx_23060191_idu.sv
// Pipelined RV32I decode stage: decoder followed by a two-entry skid buffer
// (main + skid register). YSYX_23060191_RV32E_EN selects the 16-register file.
module ysyx_23060191_idu
   import ysyx_23060191_idu_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ALU_OP_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_inst,
   input  logic [XLEN-1:0]     in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_pc,
   output logic [XLEN-1:0]     out_imm,
   output logic [4:0]          out_rs1_addr,
   output logic [4:0]          out_rs2_addr,
   output logic [4:0]          out_rd_addr,
   output logic [ALU_OP_W-1:0] out_alu_op,
   output logic                out_src1_pc,
   output logic                out_src2_imm,
   output logic                out_wen,
   output logic                out_illegal,
   output logic                out_ebreak
);

   dec_t            dec;
   buf_state_e      state_q, state_d;
   dec_t            main_q, main_d, skid_q, skid_d;
   logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
   logic            in_fire, out_fire;

   ysyx_23060191_idu_dec u_dec (
      .inst_i (in_inst),
      .dec_o  (dec)
   );

   assign in_ready  = (state_q != S_TWO);
   assign out_valid = (state_q != S_EMPTY);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   always_comb begin
      state_d   = state_q;
      main_d    = main_q;
      main_pc_d = main_pc_q;
      skid_d    = skid_q;
      skid_pc_d = skid_pc_q;
      case (state_q)
         S_EMPTY: begin
            if (in_fire) begin
               main_d    = dec;
               main_pc_d = in_pc;
               state_d   = S_ONE;
            end
         end
         S_ONE: begin
            if (in_fire && out_fire) begin
               main_d    = dec;
               main_pc_d = in_pc;
            end else if (out_fire) begin
               state_d = S_EMPTY;
            end else if (in_fire) begin
               skid_d    = dec;
               skid_pc_d = in_pc;
               state_d   = S_TWO;
            end
         end
         S_TWO: begin
            if (out_fire) begin
               main_d    = skid_q;
               main_pc_d = skid_pc_q;
               state_d   = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      // Data may still load on a flush edge, but it is never presented.
      if (flush) state_d = S_EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         main_pc_q <= '0;
         skid_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         skid_q    <= skid_d;
         main_pc_q <= main_pc_d;
         skid_pc_q <= skid_pc_d;
      end
   end

   assign out_pc       = main_pc_q;
   assign out_imm      = XLEN'($signed(main_q.imm));
   assign out_rs1_addr = main_q.rs1;
   assign out_rs2_addr = main_q.rs2;
   assign out_rd_addr  = main_q.rd;
   assign out_alu_op   = ALU_OP_W'(main_q.alu_op);
   assign out_src1_pc  = main_q.src1_pc;
   assign out_src2_imm = main_q.src2_imm;
   assign out_wen      = main_q.wen;
   assign out_illegal  = main_q.illegal;
   assign out_ebreak   = main_q.ebreak;

endmodule

// File: tb/tb_ysyx_23060191_idu.sv
// Scoreboard bench for ysyx_23060191_idu: expected entries are queued on
// input acceptance and checked in order by an independent output monitor.
module tb_ysyx_23060191_idu;

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd3, A_SLTU = 4'd4,
                          A_SRA = 4'd7, A_PASSB = 4'd10;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu;
      logic        s1pc;
      logic        s2imm;
      logic        wen;
      logic        ill;
      logic        ebrk;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst, in_pc, out_pc, out_imm;
   logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
   logic [3:0]  out_alu_op;
   logic        out_src1_pc, out_src2_imm, out_wen, out_illegal, out_ebreak;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   rec_t        sb[$];

   always #5 clk = ~clk;

   ysyx_23060191_idu #(.XLEN(32), .ALU_OP_W(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_inst      (in_inst),
      .in_pc        (in_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_imm      (out_imm),
      .out_rs1_addr (out_rs1_addr),
      .out_rs2_addr (out_rs2_addr),
      .out_rd_addr  (out_rd_addr),
      .out_alu_op   (out_alu_op),
      .out_src1_pc  (out_src1_pc),
      .out_src2_imm (out_src2_imm),
      .out_wen      (out_wen),
      .out_illegal  (out_illegal),
      .out_ebreak   (out_ebreak)
   );

   function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] imm,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [3:0] alu,
                               input logic s1pc, input logic s2imm, input logic wen,
                               input logic ill, input logic ebrk);
      rec_t r;
      r.pc = pc; r.imm = imm; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.alu = alu;
      r.s1pc = s1pc; r.s2imm = s2imm; r.wen = wen; r.ill = ill; r.ebrk = ebrk;
      return r;
   endfunction

   function automatic rec_t sample();
      return mk(out_pc, out_imm, out_rs1_addr, out_rs2_addr, out_rd_addr, out_alu_op,
                out_src1_pc, out_src2_imm, out_wen, out_illegal, out_ebreak);
   endfunction

   // Illegal entries only pin pc, alu_op, wen, illegal and ebreak.
   function automatic rec_t mask(input rec_t r, input logic ill);
      rec_t m = r;
      if (ill) begin
         m.imm = '0; m.rs1 = '0; m.rs2 = '0; m.rd = '0; m.s1pc = 1'b0; m.s2imm = 1'b0;
      end
      return m;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Output monitor: in-order scoreboard check plus hold-stability while stalled.
   initial begin
      rec_t held, cur, e;
      bit   hold_v = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_v = 1'b0;
         end else if (out_valid && out_ready) begin
            hold_v = 1'b0;
            cur = sample();
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_out: got pc 0x%08h with empty scoreboard", cur.pc);
            end else begin
               e = sb.pop_front();
               if (mask(cur, e.ill) !== mask(e, e.ill)) begin
                  n_err++;
                  $display("FAIL entry_pc_%08h: got %h expected %h", e.pc, cur, e);
               end
            end
         end else if (out_valid) begin
            cur = sample();
            if (hold_v) begin
               n_cmp++;
               if (cur !== held) begin
                  n_err++;
                  $display("FAIL stall_hold: got %h expected %h", cur, held);
               end
            end
            held   = cur;
            hold_v = 1'b1;
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   // Drives one instruction from posedge+1; returns at posedge+1 after acceptance.
   task automatic send(input logic [31:0] inst, input logic [31:0] pc, input rec_t e);
      bit          acc = 1'b0;
      int unsigned k   = 0;
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
      while (!acc && k < 40) begin
         @(negedge clk);
         if (in_ready) acc = 1'b1;
         k++;
      end
      if (acc) begin
         sb.push_back(e);
         @(posedge clk);
         #1;
      end else begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: got in_ready 0 expected 1 for pc 0x%08h", pc);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("drain_left", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] ADDI5 = 32'h0050_0093;

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_imm", out_imm, 0);
      chk("rst_alu_op", out_alu_op, 0);
      chk("rst_wen", out_wen, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // addi x1,x0,5 with one-cycle latency
      send(ADDI5, 32'h8000_0000, mk(32'h8000_0000, 5, 0, 0, 1, A_ADD, 0, 1, 1, 0, 0));
      chk("latency_out_valid", out_valid, 1);
      drain();

      // Decode sweep, back-to-back at full throughput
      send(32'h4020_8033, 32'h8000_0010, mk(32'h8000_0010, 0, 1, 2, 0, A_SUB, 0, 0, 0, 0, 0));
      send(32'hFE00_0EE3, 32'h8000_0014, mk(32'h8000_0014, 32'hFFFF_FFFC, 0, 0, 0, A_SUB, 0, 0, 0, 0, 0));
      send(32'h0010_0073, 32'h8000_0018, mk(32'h8000_0018, 0, 0, 0, 0, A_ADD, 0, 0, 0, 0, 1));
      send(32'h1234_52B7, 32'h8000_001C, mk(32'h8000_001C, 32'h1234_5000, 0, 0, 5, A_PASSB, 0, 1, 1, 0, 0));
      send(32'hFFFF_F117, 32'h8000_0020, mk(32'h8000_0020, 32'hFFFF_F000, 0, 0, 2, A_ADD, 1, 1, 1, 0, 0));
      send(32'h4072_5193, 32'h8000_0024, mk(32'h8000_0024, 32'h0000_0407, 4, 0, 3, A_SRA, 0, 1, 1, 0, 0));
      send(32'h0051_2423, 32'h8000_0028, mk(32'h8000_0028, 8, 2, 5, 0, A_ADD, 0, 1, 0, 0, 0));
      send(32'hFF9F_F0EF, 32'h8000_002C, mk(32'h8000_002C, 32'hFFFF_FFF8, 0, 0, 1, A_ADD, 1, 1, 1, 0, 0));
      send(32'h0073_6463, 32'h8000_0030, mk(32'h8000_0030, 8, 6, 7, 0, A_SLTU, 0, 0, 0, 0, 0));
      send(32'h0000_007F, 32'h8000_0034, mk(32'h8000_0034, 0, 0, 0, 0, A_ADD, 0, 0, 0, 1, 0));
      send(32'h0220_8033, 32'h8000_0038, mk(32'h8000_0038, 0, 0, 0, 0, A_ADD, 0, 0, 0, 1, 0));
      send(32'h0000_3083, 32'h8000_003C, mk(32'h8000_003C, 0, 0, 0, 0, A_ADD, 0, 0, 0, 1, 0));
      send(32'h0050_0091, 32'h8000_0040, mk(32'h8000_0040, 0, 0, 0, 0, A_ADD, 0, 0, 0, 1, 0));
      send(32'h0040_C063, 32'h8000_0044, mk(32'h8000_0044, 0, 1, 4, 0, A_SLT, 0, 0, 0, 0, 0));
`ifdef YSYX_23060191_RV32E_EN
      send(32'h0010_0813, 32'h8000_0048, mk(32'h8000_0048, 0, 0, 0, 0, A_ADD, 0, 0, 0, 1, 0));
`else
      send(32'h0010_0813, 32'h8000_0048, mk(32'h8000_0048, 1, 0, 0, 16, A_ADD, 0, 1, 1, 0, 0));
`endif
      drain();

      // Back-pressure: third input waits until one output handshake
      out_ready = 1'b0;
      send(ADDI5, 32'h8000_0100, mk(32'h8000_0100, 5, 0, 0, 1, A_ADD, 0, 1, 1, 0, 0));
      send(ADDI5, 32'h8000_0104, mk(32'h8000_0104, 5, 0, 0, 1, A_ADD, 0, 1, 1, 0, 0));
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      fork
         send(ADDI5, 32'h8000_0108, mk(32'h8000_0108, 5, 0, 0, 1, A_ADD, 0, 1, 1, 0, 0));
         begin
            repeat (2) @(negedge clk);
            chk("bp_in_ready_held", in_ready, 0);
            chk("bp_queue_depth", sb.size(), 2);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Flush in TWO with a simultaneous input: everything vanishes
      out_ready = 1'b0;
      send(32'h0070_0093, 32'h8000_0200, mk(32'h8000_0200, 7, 0, 0, 1, A_ADD, 0, 1, 1, 0, 0));
      send(32'h0080_0093, 32'h8000_0204, mk(32'h8000_0204, 8, 0, 0, 1, A_ADD, 0, 1, 1, 0, 0));
      flush    = 1'b1;
      in_valid = 1'b1;
      in_inst  = 32'h0090_0093;
      in_pc    = 32'h8000_0208;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("flush_stays_empty", out_valid, 0);
      @(posedge clk);
      #1;
      send(32'h00A0_0093, 32'h8000_0300, mk(32'h8000_0300, 10, 0, 0, 1, A_ADD, 0, 1, 1, 0, 0));
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
